// File: rtl/led_frequency_detector.sv
// LED frequency detector: measures the half-period of a looped-back square wave,
// classifies it as 100/50/10/1 Hz and reports the matching 2-bit switch code once
// enough consecutive measurements agree.
module led_frequency_detector #(
    parameter int unsigned c_CNT_100HZ = 125,
    parameter int unsigned c_CNT_50HZ  = 250,
    parameter int unsigned c_CNT_10HZ  = 1250,
    parameter int unsigned c_CNT_1HZ   = 12500,
    parameter int unsigned c_MATCH_REQ = 3,
    parameter int unsigned c_TIMEOUT   = 25000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_led_sense,
    output logic [1:0]  o_select,
    output logic        o_locked,
    output logic        o_update,
    output logic        o_no_signal,
    output logic [31:0] o_measure
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // True when |m - n| <= n/8, i.e. m lies within about 12.5% of the ideal count.
    function automatic logic in_band(input logic [31:0] m, input int unsigned n);
        logic signed [33:0] diff;
        logic signed [33:0] tol;
        diff = $signed({2'b00, m}) - $signed({2'b00, 32'(n)});
        if (diff < 0)
            diff = -diff;
        tol = $signed({2'b00, 32'(n >> 3)});
        return diff <= tol;
    endfunction

    // Maps a measurement to {valid, code}; the four bands never overlap.
    function automatic logic [2:0] classify(input logic [31:0] m);
        logic [2:0] res;
        res = 3'b000;
        if (in_band(m, c_CNT_100HZ))
            res = 3'b100;
        else if (in_band(m, c_CNT_50HZ))
            res = 3'b101;
        else if (in_band(m, c_CNT_10HZ))
            res = 3'b110;
        else if (in_band(m, c_CNT_1HZ))
            res = 3'b111;
        return res;
    endfunction

    state_t      state, state_n;
    logic        sense_p0, sense_p1, sense_p2;
    logic        edge_det;
    logic [31:0] cnt;
    logic [31:0] meas;
    logic        timeout;
    logic        band_valid;
    logic [1:0]  band_code;
    logic        cand_valid, cand_valid_n;
    logic [1:0]  cand, cand_n;
    logic [3:0]  match, match_n, match_inc;
    logic [1:0]  select_n;
    logic        locked_n, update_n, no_signal_n;
    logic [31:0] measure_n;

    // Two-flop synchronizer plus a third flop so either input edge can be detected.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sense_p0 <= 1'b0;
            sense_p1 <= 1'b0;
            sense_p2 <= 1'b0;
        end else begin
            sense_p0 <= i_led_sense;
            sense_p1 <= sense_p0;
            sense_p2 <= sense_p1;
        end
    end

    assign edge_det = sense_p1 ^ sense_p2;

    // Half-period counter: restarts on every edge, saturates at the timeout value.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            cnt <= 32'd0;
        else if (edge_det)
            cnt <= 32'd0;
        else if (cnt < 32'(c_TIMEOUT))
            cnt <= cnt + 32'd1;
    end

    assign meas    = cnt + 32'd1;
    assign timeout = (cnt == 32'(c_TIMEOUT)) && !edge_det;
    assign {band_valid, band_code} = classify(meas);
    assign match_inc = (cand_valid && (cand == band_code)) ? match + 4'd1 : 4'd1;

    // State and output registers; every output is registered.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            cand_valid  <= 1'b0;
            cand        <= 2'b00;
            match       <= 4'd0;
            o_select    <= 2'b00;
            o_locked    <= 1'b0;
            o_update    <= 1'b0;
            o_no_signal <= 1'b1;
            o_measure   <= 32'd0;
        end else begin
            state       <= state_n;
            cand_valid  <= cand_valid_n;
            cand        <= cand_n;
            match       <= match_n;
            o_select    <= select_n;
            o_locked    <= locked_n;
            o_update    <= update_n;
            o_no_signal <= no_signal_n;
            o_measure   <= measure_n;
        end
    end

    // Next-state and next-output logic; an edge always takes priority over timeout.
    always_comb begin
        state_n      = state;
        cand_valid_n = cand_valid;
        cand_n       = cand;
        match_n      = match;
        select_n     = o_select;
        locked_n     = o_locked;
        update_n     = 1'b0;
        no_signal_n  = o_no_signal;
        measure_n    = o_measure;
        case (state)
            IDLE: begin
                // The first edge only starts the count; it carries no measurement.
                if (edge_det) begin
                    state_n      = MEASURE;
                    cand_valid_n = 1'b0;
                    cand_n       = 2'b00;
                    match_n      = 4'd0;
                    no_signal_n  = 1'b0;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    measure_n = meas;
                    if (band_valid) begin
                        cand_valid_n = 1'b1;
                        cand_n       = band_code;
                        match_n      = match_inc;
                        if (match_inc >= 4'(c_MATCH_REQ)) begin
                            state_n  = LOCKED;
                            select_n = band_code;
                            locked_n = 1'b1;
                            update_n = 1'b1;
                        end
                    end else begin
                        cand_valid_n = 1'b0;
                        match_n      = 4'd0;
                    end
                end else if (timeout) begin
                    state_n     = IDLE;
                    locked_n    = 1'b0;
                    no_signal_n = 1'b1;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    measure_n = meas;
                    // A disagreeing measurement becomes the first of a new candidate run.
                    if (!(band_valid && (band_code == o_select))) begin
                        state_n      = MEASURE;
                        locked_n     = 1'b0;
                        cand_valid_n = band_valid;
                        cand_n       = band_code;
                        match_n      = band_valid ? 4'd1 : 4'd0;
                    end
                end else if (timeout) begin
                    state_n     = IDLE;
                    locked_n    = 1'b0;
                    no_signal_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_led_frequency_detector.sv
// Bench for led_frequency_detector: directed and randomized half-period sequences
// checked against a run-length reference model of the detector.
module tb_led_frequency_detector;

    localparam int TMO = 15000;
    localparam int REQ = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        led = 1'b0;
    logic [1:0]  sel;
    logic        locked;
    logic        update;
    logic        no_signal;
    logic [31:0] measure;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int in_idle;
    int run_band;
    int run_len;
    int exp_sel;
    int exp_locked;
    int exp_update;
    int exp_nosig;
    int exp_meas;
    int ideal [4] = '{125, 250, 1250, 12500};

    led_frequency_detector #(
        .c_CNT_100HZ(125),
        .c_CNT_50HZ (250),
        .c_CNT_10HZ (1250),
        .c_CNT_1HZ  (12500),
        .c_MATCH_REQ(REQ),
        .c_TIMEOUT  (TMO)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_led_sense(led),
        .o_select   (sel),
        .o_locked   (locked),
        .o_update   (update),
        .o_no_signal(no_signal),
        .o_measure  (measure)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Band index for a measurement, or -1 when it lies in no band.
    function automatic int band_of(input int m);
        for (int b = 0; b < 4; b++) begin
            if (m >= ideal[b] - ideal[b] / 8 && m <= ideal[b] + ideal[b] / 8)
                return b;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        in_idle    = 1;
        run_band   = -1;
        run_len    = 0;
        exp_sel    = 0;
        exp_locked = 0;
        exp_update = 0;
        exp_nosig  = 1;
        exp_meas   = 0;
    endfunction

    // Locked means the trailing run of identical valid bands is at least REQ long.
    function automatic void model_edge(input int gap);
        int b;
        exp_update = 0;
        if (in_idle != 0) begin
            in_idle   = 0;
            exp_nosig = 0;
            run_band  = -1;
            run_len   = 0;
        end else begin
            exp_meas = gap;
            b = band_of(gap);
            if (b < 0) begin
                run_band = -1;
                run_len  = 0;
            end else if (b == run_band) begin
                run_len++;
            end else begin
                run_band = b;
                run_len  = 1;
            end
            if (run_len == REQ)
                exp_update = 1;
            if (run_len >= REQ)
                exp_sel = run_band;
        end
        exp_locked = (in_idle == 0 && run_len >= REQ) ? 1 : 0;
    endfunction

    function automatic void model_timeout();
        in_idle    = 1;
        exp_nosig  = 1;
        exp_locked = 0;
        exp_update = 0;
        run_band   = -1;
        run_len    = 0;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".locked"}, locked, exp_locked);
        check_eq({tag, ".select"}, sel, exp_sel);
        check_eq({tag, ".update"}, update, exp_update);
        check_eq({tag, ".no_signal"}, no_signal, exp_nosig);
        check_eq({tag, ".measure"}, measure, exp_meas);
    endtask

    // Toggle the input 'gap' clocks after the previous toggle and check the result.
    // A toggle driven at a negedge becomes visible on the outputs by the third negedge.
    task automatic step(input string tag, input int gap);
        repeat (gap - 4) @(negedge clk);
        led = ~led;
        model_edge(gap);
        repeat (3) @(negedge clk);
        check_outputs(tag);
        @(negedge clk);
        check_eq({tag, ".update_after"}, update, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        led = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs(tag);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Hold the input still and wait for loss of signal (the last step used 4 negedges).
    task automatic freeze(input string tag);
        int k;
        int held_sel;
        k = 4;
        held_sel = exp_sel;
        while (no_signal == 1'b0 && k < TMO + 40) begin
            @(negedge clk);
            k++;
        end
        $display("info: no_signal rose %0d negedges after the last toggle", k);
        check_eq({tag, ".in_window"}, (k >= TMO + 3 && k <= TMO + 5) ? 1 : 0, 1);
        model_timeout();
        check_eq({tag, ".no_signal"}, no_signal, 1);
        check_eq({tag, ".locked"}, locked, 0);
        check_eq({tag, ".select_held"}, sel, held_sel);
    endtask

    initial begin
        int cat;
        int len;
        int g;
        model_reset();
        do_reset("reset");

        // 100 Hz: locks on the fourth edge
        step("idle_edge", 10);
        for (int i = 0; i < 5; i++) step("hz100", 125);
        // Switch to 10 Hz: unlock on first, relock on third
        for (int i = 0; i < 4; i++) step("hz10", 1250);
        // Out of band
        for (int i = 0; i < 3; i++) step("oob180", 180);
        // Band edges
        for (int i = 0; i < 4; i++) step("b141", 141);
        for (int i = 0; i < 4; i++) step("b140", 140);
        step("break", 180);
        for (int i = 0; i < 6; i++) step("jitter", (i % 2 == 0) ? 124 : 126);
        // Loss of signal, then recovery at 50 Hz
        freeze("timeout");
        step("resume_idle", 10);
        for (int i = 0; i < 4; i++) step("hz50", 250);

        // Randomized bursts
        for (int burst = 0; burst < 12; burst++) begin
            cat = $urandom_range(0, 9);
            len = $urandom_range(2, 5);
            for (int i = 0; i < len; i++) begin
                if (cat < 5)       g = $urandom_range(110, 140);
                else if (cat < 8)  g = $urandom_range(219, 281);
                else if (cat == 8) g = $urandom_range(141, 218);
                else               g = $urandom_range(60, 109);
                step("rand", g);
            end
        end

        // 1 Hz lock
        for (int i = 0; i < 3; i++) step("hz1", 12500);
        check_eq("hz1.final_locked", locked, 1);
        check_eq("hz1.final_select", sel, 3);

        // Reset while locked
        do_reset("reset_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
